control_cmd_readrect: RTL and testbench

Parametrised successor to the single-row pixel loader in the command path. It consumes a byte stream from the command dispatcher. The stream is a 6-byte rectangle header followed by pixel payload. The block emits one framebuffer RAM write per payload byte, covering an arbitrary rows × columns window with wrap-around at the panel edges. It sits between the command dispatcher (byte-rate `enable` strobes) and the framebuffer write port, alongside the existing row loader.

---
 rtl/calc_pkg.sv | 17 +
 rtl/cmd_readrect_pkg.sv | 13 +
 rtl/params_pkg.sv | 8 +
 rtl/wrap_counter.sv | 42 ++++
 rtl/control_cmd_readrect.sv | 192 +++++++++++++++++++
 tb/tb_control_cmd_readrect.sv | 293 +++++++++++++++++++++++++++++
 6 files changed

// File: rtl/calc_pkg.sv
// Address-width helpers derived from the panel geometry.
// Latency: n/a (elaboration-time functions).
// Backpressure: n/a.
package calc_pkg;
  // Never return zero so a 1-entry dimension still gets a usable 1-bit port.
  function automatic int num_row_address_bits(input int height);
    return (height <= 2) ? 1 : $clog2(height);
  endfunction

  function automatic int num_column_address_bits(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

  function automatic int num_pixelcolorselect_bits(input int bytes_per_pixel);
    return (bytes_per_pixel <= 2) ? 1 : $clog2(bytes_per_pixel);
  endfunction
endpackage

// File: rtl/cmd_readrect_pkg.sv
// Shared constants and state type for the rectangle pixel loader.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cmd_readrect_pkg;
  localparam int READRECT_HEADER_BYTES = 6;
  localparam logic [2:0] HDR_LAST_IDX = 3'(READRECT_HEADER_BYTES - 1);

  typedef enum logic [1:0] {
    HDR     = 2'd0,
    PAYLOAD = 2'd1,
    DONE    = 2'd2
  } readrect_state_t;
endpackage

// File: rtl/params_pkg.sv
// Panel-wide defaults shared by the command-path blocks.
// Latency: n/a (constants only).
// Backpressure: n/a.
package params_pkg;
  localparam int BYTES_PER_PIXEL = 2;
  localparam int PIXEL_HEIGHT    = 32;
  localparam int PIXEL_WIDTH     = 64;
endpackage

// File: rtl/wrap_counter.sv
// Loadable modulo-LIMIT counter; wrap_o flags the last value before rollover.
// Latency: load/increment take effect on the next clock edge.
// Backpressure: none; load has priority over increment.
module wrap_counter #(
  parameter int LIMIT = 2,
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o,
  output logic             wrap_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  assign wrap_o  = (count_q == WIDTH'(LIMIT - 1));
  assign count_o = count_q;

  // Next count: load wins, otherwise step and roll over after LIMIT-1.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (inc_i) begin
      count_d = wrap_o ? '0 : count_q + WIDTH'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/control_cmd_readrect.sv
// Parses a 6-byte rectangle header then emits one framebuffer write per payload byte.
// Latency: write strobe/address/data appear the cycle after the byte is accepted; done one cycle after the last write.
// Backpressure: none; accepts one byte per clock, strobes arriving in DONE are dropped.
module control_cmd_readrect
  import cmd_readrect_pkg::*;
#(
  parameter int BYTES_PER_PIXEL = params_pkg::BYTES_PER_PIXEL,
  parameter int PIXEL_HEIGHT    = params_pkg::PIXEL_HEIGHT,
  parameter int PIXEL_WIDTH     = params_pkg::PIXEL_WIDTH,
  parameter bit PIXEL_MSB_FIRST = 1'b1,
  localparam int RW = calc_pkg::num_row_address_bits(PIXEL_HEIGHT),
  localparam int CW = calc_pkg::num_column_address_bits(PIXEL_WIDTH),
  localparam int PW = calc_pkg::num_pixelcolorselect_bits(BYTES_PER_PIXEL)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic [7:0]    data_in,
  output logic [RW-1:0] row,
  output logic [CW-1:0] column,
  output logic [PW-1:0] pixel,
  output logic [7:0]    data_out,
  output logic          ram_write_enable,
  output logic          ram_access_start,
  output logic          done
);

  readrect_state_t state_q;
  logic [2:0]      hdr_idx_q;
  logic [7:0]      row_start_raw_q;
  logic [7:0]      row_cnt_m1_q;
  logic [15:0]     col_start_raw_q;
  logic [7:0]      col_cnt_hi_q;
  logic [15:0]     col_cnt_m1_q;
  logic [CW-1:0]   col_reload_q;
  logic [7:0]      rows_left_q;
  logic [15:0]     cols_left_q;

  logic [RW-1:0]   row_q;
  logic [CW-1:0]   column_q;
  logic [PW-1:0]   pixel_q;
  logic [7:0]      data_out_q;
  logic            wr_en_q;
  logic            start_q;
  logic            done_q;

  logic [RW-1:0]   row_cnt;
  logic [CW-1:0]   col_cnt;
  logic [PW-1:0]   pix_cnt;
  logic            row_wrap;
  logic            col_wrap;
  logic            pix_wrap;

  logic            hdr_last;
  logic            pay_accept;
  logic            row_end;
  logic [RW-1:0]   row_start_d;
  logic [CW-1:0]   col_start_d;
  logic [CW-1:0]   col_load_val;
  logic [PW-1:0]   pix_sel;

  // Off-panel start coordinates restart at the panel origin.
  assign row_start_d = (int'(row_start_raw_q) >= PIXEL_HEIGHT) ? '0 : RW'(row_start_raw_q);
  assign col_start_d = (int'(col_start_raw_q) >= PIXEL_WIDTH)  ? '0 : CW'(col_start_raw_q);

  assign hdr_last     = (state_q == HDR) && enable && (hdr_idx_q == HDR_LAST_IDX);
  assign pay_accept   = (state_q == PAYLOAD) && enable;
  // End of a row is decided by the remaining-column count, not by address compare.
  assign row_end      = pay_accept && pix_wrap && (cols_left_q == 16'd0);
  assign col_load_val = hdr_last ? col_start_d : col_reload_q;
  assign pix_sel      = PIXEL_MSB_FIRST ? (PW'(BYTES_PER_PIXEL - 1) - pix_cnt) : pix_cnt;

  wrap_counter #(.LIMIT(BYTES_PER_PIXEL), .WIDTH(PW)) u_pix_cnt (
    .clk_i      (clk),
    .reset_i    (reset),
    .load_i     (hdr_last),
    .load_val_i ('0),
    .inc_i      (pay_accept),
    .count_o    (pix_cnt),
    .wrap_o     (pix_wrap)
  );

  wrap_counter #(.LIMIT(PIXEL_WIDTH), .WIDTH(CW)) u_col_cnt (
    .clk_i      (clk),
    .reset_i    (reset),
    .load_i     (hdr_last || row_end),
    .load_val_i (col_load_val),
    .inc_i      (pay_accept && pix_wrap),
    .count_o    (col_cnt),
    .wrap_o     (col_wrap)
  );

  wrap_counter #(.LIMIT(PIXEL_HEIGHT), .WIDTH(RW)) u_row_cnt (
    .clk_i      (clk),
    .reset_i    (reset),
    .load_i     (hdr_last),
    .load_val_i (row_start_d),
    .inc_i      (row_end),
    .count_o    (row_cnt),
    .wrap_o     (row_wrap)
  );

  // Address wrap flags are only needed inside the counters themselves.
  logic unused_wraps;
  assign unused_wraps = col_wrap ^ row_wrap;

  // Header capture, payload sequencing and registered write-port outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= HDR;
      hdr_idx_q       <= '0;
      row_start_raw_q <= '0;
      row_cnt_m1_q    <= '0;
      col_start_raw_q <= '0;
      col_cnt_hi_q    <= '0;
      col_cnt_m1_q    <= '0;
      col_reload_q    <= '0;
      rows_left_q     <= '0;
      cols_left_q     <= '0;
      row_q           <= '0;
      column_q        <= '0;
      pixel_q         <= '0;
      data_out_q      <= '0;
      wr_en_q         <= 1'b0;
      start_q         <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        HDR: begin
          if (enable) begin
            if (hdr_idx_q == HDR_LAST_IDX) begin
              cols_left_q  <= {col_cnt_hi_q, data_in};
              col_cnt_m1_q <= {col_cnt_hi_q, data_in};
              rows_left_q  <= row_cnt_m1_q;
              col_reload_q <= col_start_d;
              start_q      <= 1'b1;
              hdr_idx_q    <= '0;
              state_q      <= PAYLOAD;
            end else begin
              case (hdr_idx_q)
                3'd0:    row_start_raw_q       <= data_in;
                3'd1:    row_cnt_m1_q          <= data_in;
                3'd2:    col_start_raw_q[15:8] <= data_in;
                3'd3:    col_start_raw_q[7:0]  <= data_in;
                default: col_cnt_hi_q          <= data_in;
              endcase
              hdr_idx_q <= hdr_idx_q + 3'd1;
            end
          end
        end
        PAYLOAD: begin
          if (enable) begin
            wr_en_q    <= 1'b1;
            row_q      <= row_cnt;
            column_q   <= col_cnt;
            pixel_q    <= pix_sel;
            data_out_q <= data_in;
            if (pix_wrap) begin
              if (cols_left_q == 16'd0) begin
                cols_left_q <= col_cnt_m1_q;
                if (rows_left_q == 8'd0) begin
                  state_q <= DONE;
                end else begin
                  rows_left_q <= rows_left_q - 8'd1;
                end
              end else begin
                cols_left_q <= cols_left_q - 16'd1;
              end
            end
          end
        end
        DONE: begin
          done_q  <= 1'b1;
          state_q <= HDR;
        end
        default: state_q <= HDR;
      endcase
    end
  end

  assign row              = row_q;
  assign column           = column_q;
  assign pixel            = pixel_q;
  assign data_out         = data_out_q;
  assign ram_write_enable = wr_en_q;
  assign ram_access_start = start_q;
  assign done             = done_q;

endmodule

// File: tb/tb_control_cmd_readrect.sv
// Self-checking bench for control_cmd_readrect: directed and random rectangles vs a loop model.
// Latency: n/a (testbench).
// Backpressure: n/a.
module tb_control_cmd_readrect;
  localparam int H   = 32;
  localparam int W   = 64;
  localparam int BPP = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable_a;
  logic       enable_b;
  logic [7:0] data_in;

  logic [4:0] row_a, row_b;
  logic [5:0] col_a, col_b;
  logic [0:0] px_a, px_b;
  logic [7:0] dout_a, dout_b;
  logic       wr_a, wr_b, st_a, st_b, dn_a, dn_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  control_cmd_readrect #(
    .BYTES_PER_PIXEL(BPP), .PIXEL_HEIGHT(H), .PIXEL_WIDTH(W), .PIXEL_MSB_FIRST(1'b1)
  ) dut_a (
    .clk(clk), .reset(reset), .enable(enable_a), .data_in(data_in),
    .row(row_a), .column(col_a), .pixel(px_a), .data_out(dout_a),
    .ram_write_enable(wr_a), .ram_access_start(st_a), .done(dn_a)
  );

  control_cmd_readrect #(
    .BYTES_PER_PIXEL(BPP), .PIXEL_HEIGHT(H), .PIXEL_WIDTH(W), .PIXEL_MSB_FIRST(1'b0)
  ) dut_b (
    .clk(clk), .reset(reset), .enable(enable_b), .data_in(data_in),
    .row(row_b), .column(col_b), .pixel(px_b), .data_out(dout_b),
    .ram_write_enable(wr_b), .ram_access_start(st_b), .done(dn_b)
  );

  // Monitor state.
  logic [31:0] obs_q[$];
  logic [31:0] exp_q[$];
  logic [7:0]  pl_q[$];
  int start_cnt, done_cnt, last_wr_cyc, done_cyc, overlap_cnt, stray_cnt;
  logic en_seen_a = 1'b0;
  logic en_seen_b = 1'b0;

  always @(posedge clk) begin
    cyc       <= cyc + 1;
    en_seen_a <= enable_a;
    en_seen_b <= enable_b;
  end

  always @(negedge clk) begin
    if (wr_a) begin
      obs_q.push_back({3'b0, row_a, 2'b0, col_a, 7'b0, px_a, dout_a});
      last_wr_cyc = cyc;
      if (!en_seen_a) stray_cnt++;
    end
    if (wr_b) begin
      obs_q.push_back({3'b0, row_b, 2'b0, col_b, 7'b0, px_b, dout_b});
      last_wr_cyc = cyc;
      if (!en_seen_b) stray_cnt++;
    end
    if (st_a || st_b) start_cnt++;
    if ((st_a && wr_a) || (st_b && wr_b)) overlap_cnt++;
    if (dn_a || dn_b) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send_byte(input bit lsb, input logic [7:0] b);
    if (lsb) enable_b = 1'b1;
    else     enable_a = 1'b1;
    data_in = b;
    tick();
    enable_a = 1'b0;
    enable_b = 1'b0;
  endtask

  task automatic clear_mon();
    obs_q.delete();
    start_cnt   = 0;
    done_cnt    = 0;
    overlap_cnt = 0;
    stray_cnt   = 0;
    last_wr_cyc = -100;
    done_cyc    = -1;
  endtask

  task automatic send_header(input bit lsb, input int rs, input int rc, input int cs, input int cc,
                             input int gap);
    logic [15:0] c16;
    logic [15:0] n16;
    c16 = 16'(cs);
    n16 = 16'(cc);
    send_byte(lsb, 8'(rs)); idle(gap);
    send_byte(lsb, 8'(rc)); idle(gap);
    send_byte(lsb, c16[15:8]); idle(gap);
    send_byte(lsb, c16[7:0]); idle(gap);
    send_byte(lsb, n16[15:8]); idle(gap);
    send_byte(lsb, n16[7:0]); idle(gap);
  endtask

  // Reference: rows x cols x bytes visited with modulo-panel addressing.
  task automatic build_expected(input int rs, input int rc, input int cs, input int cc,
                                input bit msb, input int nbytes);
    int idx;
    int r0;
    int c0;
    exp_q.delete();
    idx = 0;
    r0 = (rs >= H) ? 0 : rs;
    c0 = (cs >= W) ? 0 : cs;
    for (int r = 0; r <= rc; r++)
      for (int c = 0; c <= cc; c++)
        for (int b = 0; b < BPP; b++) begin
          if (idx < nbytes)
            exp_q.push_back({8'((r0 + r) % H), 8'((c0 + c) % W), 8'(msb ? (BPP - 1 - b) : b), pl_q[idx]});
          idx++;
        end
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    enable_a = 1'b0;
    enable_b = 1'b0;
    data_in  = 8'h00;
    clear_mon();
    idle(3);
    checks++;
    if ({row_a, col_a, px_a, dout_a, wr_a, st_a, dn_a} !== 22'd0) begin
      errors++;
      $display("FAIL reset_outputs_a got %h want 0", {row_a, col_a, px_a, dout_a, wr_a, st_a, dn_a});
    end
    checks++;
    if ({row_b, col_b, px_b, dout_b, wr_b, st_b, dn_b} !== 22'd0) begin
      errors++;
      $display("FAIL reset_outputs_b got %h want 0", {row_b, col_b, px_b, dout_b, wr_b, st_b, dn_b});
    end
    // Strobes while reset is held must be ignored.
    send_header(1'b0, 3, 0, 5, 0, 0);
    reset = 1'b0;
    idle(4);
    checks++;
    if (start_cnt !== 0) begin
      errors++;
      $display("FAIL reset_wins_start got %0d want 0", start_cnt);
    end
  endtask

  task automatic test_reset_mid();
    clear_mon();
    pl_q.delete();
    for (int i = 0; i < 16; i++) pl_q.push_back(8'($urandom));
    build_expected(4, 1, 10, 3, 1'b1, 2);
    send_header(1'b0, 4, 1, 10, 3, 0);
    send_byte(1'b0, pl_q[0]);
    send_byte(1'b0, pl_q[1]);
    reset = 1'b1;
    tick();
    checks++;
    if ({row_a, col_a, px_a, dout_a, wr_a, st_a, dn_a} !== 22'd0) begin
      errors++;
      $display("FAIL midreset_outputs got %h want 0", {row_a, col_a, px_a, dout_a, wr_a, st_a, dn_a});
    end
    reset = 1'b0;
    idle(6);
    checks++;
    if (obs_q.size() !== 2) begin
      errors++;
      $display("FAIL midreset_writes got %0d want 2", obs_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < 2; i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL midreset_write%0d got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (done_cnt !== 0) begin
      errors++;
      $display("FAIL midreset_done got %0d want 0", done_cnt);
    end
  endtask

  // Directed table followed by random rectangles, each run through the full pipeline.
  int rs_t [7] = '{3, 0, 31, 31, 255, 7, 30};
  int rc_t [7] = '{0, 0, 1, 1, 0, 0, 2};
  int cs_t [7] = '{5, 63, 2, 2, 0, 'h1234, 60};
  int cc_t [7] = '{0, 1, 1, 1, 0, 2, 69};
  int gp_t [7] = '{0, 0, 0, 15, 0, 0, 0};
  int lb_t [7] = '{0, 0, 0, 0, 1, 0, 0};

  task automatic test_rectangles();
    int rs, rc, cs, cc, gap, nb;
    bit lsb;
    for (int t = 0; t < 13; t++) begin
      if (t < 7) begin
        rs = rs_t[t]; rc = rc_t[t]; cs = cs_t[t]; cc = cc_t[t]; gap = gp_t[t]; lsb = lb_t[t][0];
      end else begin
        rs  = int'($urandom_range(0, 40));
        rc  = int'($urandom_range(0, 3));
        cs  = int'($urandom_range(0, 90));
        cc  = int'($urandom_range(0, 7));
        gap = int'($urandom_range(0, 2));
        lsb = 1'($urandom_range(0, 1));
      end
      nb = (rc + 1) * (cc + 1) * BPP;
      // The sparse run replays the previous stream unchanged.
      if (t != 3) begin
        pl_q.delete();
        if (t == 0) begin
          pl_q.push_back(8'hAA);
          pl_q.push_back(8'hBB);
        end else begin
          for (int i = 0; i < nb; i++) pl_q.push_back(8'($urandom));
        end
      end
      build_expected(rs, rc, cs, cc, !lsb, nb);
      clear_mon();
      send_header(lsb, rs, rc, cs, cc, gap);
      for (int i = 0; i < nb; i++) begin
        send_byte(lsb, pl_q[i]);
        idle(gap);
      end
      idle(4);

      checks++;
      if (obs_q.size() !== exp_q.size()) begin
        errors++;
        $display("FAIL rect%0d_count got %0d want %0d", t, obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL rect%0d_write%0d got %h want %h", t, i, obs_q[i], exp_q[i]);
        end
      end
      if (t == 0 && obs_q.size() >= 2) begin
        checks++;
        if (obs_q[0] !== 32'h030501AA || obs_q[1] !== 32'h030500BB) begin
          errors++;
          $display("FAIL single_pixel got %h %h want 030501aa 030500bb", obs_q[0], obs_q[1]);
        end
      end
      checks++;
      if (start_cnt !== 1) begin
        errors++;
        $display("FAIL rect%0d_start got %0d want 1", t, start_cnt);
      end
      checks++;
      if (done_cnt !== 1) begin
        errors++;
        $display("FAIL rect%0d_done_count got %0d want 1", t, done_cnt);
      end
      checks++;
      if (done_cyc !== last_wr_cyc + 1) begin
        errors++;
        $display("FAIL rect%0d_done_timing got %0d want %0d", t, done_cyc, last_wr_cyc + 1);
      end
      checks++;
      if (overlap_cnt !== 0 || stray_cnt !== 0) begin
        errors++;
        $display("FAIL rect%0d_strobes overlap %0d stray %0d want 0 0", t, overlap_cnt, stray_cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_rectangles();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
